// File: rtl/buffer_drain_if.sv
// buffer_drain_if: write-buffer, memory-write and status signals of buffer_drain
interface buffer_drain_if;
  logic        en;
  logic        empty;
  logic [31:0] buf_data;
  logic        rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr;
  logic        mem_ack;
  logic        err_clr;
  logic        busy;
  logic        err;
  logic [15:0] wr_count;
  modport slave (
    input  en, empty, buf_data, mem_ack, err_clr,
    output rd, mem_addr, mem_data, mem_wr, busy, err, wr_count
  );
  modport master (
    output en, empty, buf_data, mem_ack, err_clr,
    input  rd, mem_addr, mem_data, mem_wr, busy, err, wr_count
  );
endinterface

// File: rtl/buffer_drain.sv
// buffer_drain: drains address/data word pairs from a write buffer into a memory write port
module buffer_drain #(
  parameter int TIMEOUT = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  buffer_drain_if.slave bus
);
  typedef enum logic [2:0] {IDLE, A_RD, A_CAP, D_WAIT, D_RD, D_CAP, MEM_WR} state_t;
  state_t      state_q, state_d;
  logic        rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [15:0] cnt_q, cnt_d, timer_q, timer_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  // sequence control: read address word, read data word, then hold the write until ack or timeout
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    wr_d    = wr_q;
    err_d   = err_q & ~bus.err_clr;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:   if (bus.en && !bus.empty) begin
        rd_d    = 1'b1;
        state_d = A_RD;
      end
      A_RD:   state_d = A_CAP;
      A_CAP:  begin
        addr_d  = bus.buf_data;
        state_d = D_WAIT;
      end
      D_WAIT: if (!bus.empty) begin
        rd_d    = 1'b1;
        state_d = D_RD;
      end
      D_RD:   state_d = D_CAP;
      D_CAP:  begin
        data_d  = bus.buf_data;
        wr_d    = 1'b1;
        timer_d = '0;
        state_d = MEM_WR;
      end
      MEM_WR: if (bus.mem_ack) begin
        wr_d    = 1'b0;
        cnt_d   = cnt_q + 16'd1;
        state_d = IDLE;
      end else if (timer_q == 16'(TIMEOUT - 1)) begin
        wr_d    = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        timer_d = timer_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign bus.rd       = rd_q;
  assign bus.mem_wr   = wr_q;
  assign bus.err      = err_q;
  assign bus.wr_count = cnt_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_buffer_drain.sv
// tb_buffer_drain: directed vectors and corner sequences for buffer_drain with a queue-backed write buffer
module tb_buffer_drain;
  logic clk, rst;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  buffer_drain_if bus();
  buffer_drain #(.TIMEOUT(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic        en;
    logic        ack;
    logic        clr;
    logic [19:0] exp;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] w);
    q.push_back(w);
    bus.empty = 1'b0;
  endtask
  task automatic tick();
    logic rp, ep;
    rp = bus.rd;
    ep = bus.empty;
    @(posedge clk);
    #1;
    chk("rd_rule", 32'(bus.rd & (rp | ep)), 32'd0);
    if (bus.rd && q.size() > 0) bus.buf_data = q.pop_front();
    bus.empty = (q.size() == 0);
  endtask
  task automatic step(input logic en, input logic ack, input logic clr);
    bus.en = en;
    bus.mem_ack = ack;
    bus.err_clr = clr;
    tick();
  endtask
  task automatic run_xact(input int ack_at, input logic clr, output int n);
    step(1, 0, 0);
    for (int k = 0; k < 20 && !bus.mem_wr; k++) step(0, 0, 0);
    chk("wr_start", 32'(bus.mem_wr), 32'd1);
    n = 0;
    while (bus.mem_wr && n < 20) begin
      step(0, n == ack_at, clr);
      n++;
    end
    bus.err_clr = 1'b0;
  endtask
  initial begin
    int n;
    vt[0] = '{1'b1, 1'b0, 1'b0, 20'hA0000};
    vt[1] = '{1'b0, 1'b0, 1'b0, 20'h20000};
    vt[2] = '{1'b0, 1'b1, 1'b0, 20'h20000};
    vt[3] = '{1'b0, 1'b0, 1'b0, 20'hA0000};
    vt[4] = '{1'b0, 1'b0, 1'b0, 20'h20000};
    vt[5] = '{1'b0, 1'b0, 1'b0, 20'h60000};
    vt[6] = '{1'b0, 1'b0, 1'b0, 20'h60000};
    vt[7] = '{1'b0, 1'b0, 1'b0, 20'h60000};
    vt[8] = '{1'b0, 1'b1, 1'b0, 20'h00001};
    vt[9] = '{1'b1, 1'b1, 1'b0, 20'h00001};
    rst = 1'b1;
    bus.en = 1'b0;
    bus.empty = 1'b1;
    bus.buf_data = '0;
    bus.mem_ack = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {28'd0, bus.rd, bus.mem_wr, bus.busy, bus.err}, 32'd0);
    chk("reset_cnt", 32'(bus.wr_count), 32'd0);
    chk("reset_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(32'h0000_1000);
    push(32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) begin
      step(vt[i].en, vt[i].ack, vt[i].clr);
      chk($sformatf("vec%0d", i), {12'd0, bus.rd, bus.mem_wr, bus.busy, bus.err, bus.wr_count}, {12'd0, vt[i].exp});
    end
    chk("basic_addr", bus.mem_addr, 32'h0000_1000);
    chk("basic_data", bus.mem_data, 32'hDEAD_BEEF);
    bus.mem_ack = 1'b0;
    push(32'h0000_2000);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      chk($sformatf("dwait%0d", i), {30'd0, bus.busy, bus.rd}, 32'd2);
    end
    push(32'hAAAA_5555);
    step(0, 0, 0);
    chk("dwait_rd", 32'(bus.rd), 32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("dwait_wr", 32'(bus.mem_wr), 32'd1);
    step(0, 1, 0);
    chk("dwait_cnt", 32'(bus.wr_count), 32'd2);
    chk("dwait_addr", bus.mem_addr, 32'h0000_2000);
    chk("dwait_data", bus.mem_data, 32'hAAAA_5555);
    bus.mem_ack = 1'b0;
    push(32'h0000_3000);
    push(32'h3333_3333);
    run_xact(-1, 1'b0, n);
    chk("to_cycles", 32'(n), 32'd4);
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_cnt", 32'(bus.wr_count), 32'd2);
    chk("to_data", bus.mem_data, 32'h3333_3333);
    step(0, 0, 1);
    chk("errclr", 32'(bus.err), 32'd0);
    push(32'h0000_3100);
    push(32'h3111_3111);
    run_xact(-1, 1'b1, n);
    chk("set_wins", 32'(bus.err), 32'd1);
    step(0, 0, 1);
    chk("errclr2", 32'(bus.err), 32'd0);
    push(32'h0000_4000);
    push(32'h4444_4444);
    run_xact(3, 1'b0, n);
    chk("ack_edge_cycles", 32'(n), 32'd4);
    chk("ack_edge_err", 32'(bus.err), 32'd0);
    chk("ack_edge_cnt", 32'(bus.wr_count), 32'd3);
    bus.mem_ack = 1'b0;
    push(32'h0000_4800);
    push(32'h4888_4888);
    run_xact(-1, 1'b0, n);
    chk("pre_rst_err", 32'(bus.err), 32'd1);
    push(32'h0000_5000);
    push(32'h5555_5555);
    step(1, 0, 0);
    for (int k = 0; k < 20 && !bus.mem_wr; k++) step(0, 0, 0);
    chk("rst_wr_seen", 32'(bus.mem_wr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_flags", {28'd0, bus.rd, bus.mem_wr, bus.busy, bus.err}, 32'd0);
    chk("async_cnt", 32'(bus.wr_count), 32'd0);
    chk("async_addr", bus.mem_addr, 32'd0);
    chk("async_data", bus.mem_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(32'h0000_6000);
    push(32'h6666_6666);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_rst_idle", {30'd0, bus.rd, bus.busy}, 32'd0);
    run_xact(0, 1'b0, n);
    chk("restart_cnt", 32'(bus.wr_count), 32'd1);
    chk("restart_addr", bus.mem_addr, 32'h0000_6000);
    chk("restart_data", bus.mem_data, 32'h6666_6666);
    bus.mem_ack = 1'b0;
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    push(32'h0000_7000);
    push(32'h7777_7777);
    run_xact(0, 1'b0, n);
    chk("cnt_ffff", 32'(bus.wr_count), 32'h0000_FFFF);
    bus.mem_ack = 1'b0;
    push(32'h0000_7100);
    push(32'h7111_7111);
    run_xact(1, 1'b0, n);
    chk("cnt_wrap", 32'(bus.wr_count), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
